io_mmio_ctrl: RTL and testbench

//  Parametrised memory-mapped I/O controller on the CPU data bus, next to dmem in the MEM stage.

---
 rtl/io_mmio_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_io_mmio_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller on the CPU data bus: HEX/LEDR output registers,
// debounced KEY/SW inputs with sticky status, an interval timer and a level IRQ.

module io_mmio_debounce #(
    parameter int W        = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb,
    output logic         change
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [W-1:0]  meta, sync, sync_d;
    logic [CW-1:0] cnt, cnt_nx;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        cnt_nx = (sync != sync_d) ? CW'(1) : cnt + CW'(1);
        change = (sync != deb) && (cnt_nx == CW'(DEBOUNCE));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= '0;
            sync   <= '0;
            sync_d <= '0;
            deb    <= '0;
            cnt    <= '0;
        end else begin
            meta   <= raw;
            sync   <= meta;
            sync_d <= sync;
            if (sync == deb) begin
                cnt <= '0;
            end else if (change) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt_nx;
            end
        end
    end
endmodule

module io_mmio_ctrl #(
    parameter int               DBITS    = 32,
    parameter logic [DBITS-1:0] BASEADDR = 32'hFFFFF000,
    parameter int               HEXBITS  = 24,
    parameter logic [HEXBITS-1:0] HEXRESET = 24'hFEDEAD,
    parameter int               NLEDR    = 10,
    parameter int               NKEY     = 4,
    parameter int               NSW      = 10,
    parameter int               DEBOUNCE = 10000,
    parameter int               TICKCLKS = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   addr,
    input  logic [DBITS-1:0]   wdata,
    input  logic               we,
    output logic [DBITS-1:0]   rdata,
    output logic               hit,
    output logic               irq,
    input  logic [NKEY-1:0]    key_n,
    input  logic [NSW-1:0]     sw,
    output logic [HEXBITS-1:0] hex_out,
    output logic [NLEDR-1:0]   ledr_out
);
    localparam logic [8:0] OFF_HEX   = 9'h000;
    localparam logic [8:0] OFF_LEDR  = 9'h020;
    localparam logic [8:0] OFF_KDATA = 9'h080;
    localparam logic [8:0] OFF_KCTRL = 9'h084;
    localparam logic [8:0] OFF_SDATA = 9'h090;
    localparam logic [8:0] OFF_SCTRL = 9'h094;
    localparam logic [8:0] OFF_TCNT  = 9'h100;
    localparam logic [8:0] OFF_TLIM  = 9'h104;
    localparam logic [8:0] OFF_TCTL  = 9'h108;
    localparam int PW = (TICKCLKS > 1) ? $clog2(TICKCLKS) : 1;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    // CPU write applies first (0 clears, 1 keeps); a same-cycle event then wins over a clear.
    function automatic ctrl_t ctrl_update(input ctrl_t cur, input logic wr,
                                          input logic [DBITS-1:0] wd, input logic ev);
        ctrl_t nx;
        nx = cur;
        if (wr) begin
            nx.ie  = wd[8];
            nx.rdy = cur.rdy & wd[0];
            nx.ovr = cur.ovr & wd[2];
        end
        if (ev) begin
            nx.ovr = nx.ovr | nx.rdy;
            nx.rdy = 1'b1;
        end
        return nx;
    endfunction

    function automatic logic [DBITS-1:0] ctrl_word(input ctrl_t c);
        logic [DBITS-1:0] w;
        w    = '0;
        w[8] = c.ie;
        w[2] = c.ovr;
        w[0] = c.rdy;
        return w;
    endfunction

    logic [DBITS-1:0] off;
    logic             in_win;
    logic sel_hex, sel_ledr, sel_kctrl, sel_sctrl, sel_tcnt, sel_tlim, sel_tctl;

    logic [NKEY-1:0]  key_deb;
    logic [NSW-1:0]   sw_deb;
    logic             key_change, sw_change;
    ctrl_t            kctrl, sctrl, tctl;
    logic [DBITS-1:0] tcnt, tlim;
    logic [PW-1:0]    presc;
    logic             tick, wrap, wr_tcnt, wr_tlim;

    io_mmio_debounce #(.W(NKEY), .DEBOUNCE(DEBOUNCE)) u_key_deb (
        .clk(clk), .reset(reset), .raw(~key_n), .deb(key_deb), .change(key_change)
    );

    io_mmio_debounce #(.W(NSW), .DEBOUNCE(DEBOUNCE)) u_sw_deb (
        .clk(clk), .reset(reset), .raw(sw), .deb(sw_deb), .change(sw_change)
    );

    assign off    = addr - BASEADDR;
    assign in_win = (off[DBITS-1:9] == '0);

    always_comb begin
        rdata     = '0;
        hit       = 1'b0;
        sel_hex   = 1'b0;
        sel_ledr  = 1'b0;
        sel_kctrl = 1'b0;
        sel_sctrl = 1'b0;
        sel_tcnt  = 1'b0;
        sel_tlim  = 1'b0;
        sel_tctl  = 1'b0;
        if (in_win) begin
            case (off[8:0])
                OFF_HEX:   begin hit = 1'b1; sel_hex   = 1'b1; rdata = DBITS'(hex_out);  end
                OFF_LEDR:  begin hit = 1'b1; sel_ledr  = 1'b1; rdata = DBITS'(ledr_out); end
                OFF_KDATA: begin hit = 1'b1;                   rdata = DBITS'(key_deb);  end
                OFF_KCTRL: begin hit = 1'b1; sel_kctrl = 1'b1; rdata = ctrl_word(kctrl); end
                OFF_SDATA: begin hit = 1'b1;                   rdata = DBITS'(sw_deb);   end
                OFF_SCTRL: begin hit = 1'b1; sel_sctrl = 1'b1; rdata = ctrl_word(sctrl); end
                OFF_TCNT:  begin hit = 1'b1; sel_tcnt  = 1'b1; rdata = tcnt;             end
                OFF_TLIM:  begin hit = 1'b1; sel_tlim  = 1'b1; rdata = tlim;             end
                OFF_TCTL:  begin hit = 1'b1; sel_tctl  = 1'b1; rdata = ctrl_word(tctl);  end
                default:   ;
            endcase
        end
    end

    assign wr_tcnt = we & sel_tcnt;
    assign wr_tlim = we & sel_tlim;
    assign tick    = (tlim != '0) && (presc == PW'(TICKCLKS - 1));
    assign wrap    = tick && (tcnt >= tlim - DBITS'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_out  <= HEXRESET;
            ledr_out <= '0;
            kctrl    <= '0;
            sctrl    <= '0;
            tctl     <= '0;
            tcnt     <= '0;
            tlim     <= '0;
            presc    <= '0;
            irq      <= 1'b0;
        end else begin
            if (we && sel_hex)  hex_out  <= wdata[HEXBITS-1:0];
            if (we && sel_ledr) ledr_out <= wdata[NLEDR-1:0];
            if (wr_tlim)        tlim     <= wdata;

            // A stopped timer and any TLIM/TCNT write both restart the prescaler.
            if (wr_tcnt || wr_tlim || tlim == '0 || tick) presc <= '0;
            else                                          presc <= presc + PW'(1);

            if (wr_tcnt)   tcnt <= wdata;
            else if (tick) tcnt <= wrap ? '0 : tcnt + DBITS'(1);

            kctrl <= ctrl_update(kctrl, we & sel_kctrl, wdata, key_change);
            sctrl <= ctrl_update(sctrl, we & sel_sctrl, wdata, sw_change);
            tctl  <= ctrl_update(tctl,  we & sel_tctl,  wdata, wrap & ~wr_tcnt);

            irq <= |{kctrl.rdy & kctrl.ie, sctrl.rdy & sctrl.ie, tctl.rdy & tctl.ie};
        end
    end
endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl with DEBOUNCE=4 and TICKCLKS=3; expected values are hand-derived.

module tb_io_mmio_ctrl;
    localparam logic [31:0] B = 32'hFFFFF000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, hit, irq;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [23:0] hex_out;
    logic [9:0]  ledr_out;

    int n_vec  = 0;
    int n_miss = 0;

    io_mmio_ctrl #(.DEBOUNCE(4), .TICKCLKS(3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .hit(hit), .irq(irq), .key_n(key_n), .sw(sw),
        .hex_out(hex_out), .ledr_out(ledr_out)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] o, input logic [31:0] d);
        addr  = B + {20'h0, o};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] o, input logic [31:0] exp);
        addr = B + {20'h0, o};
        we   = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; we = 1'b0; addr = B; wdata = '0; key_n = 4'hF; sw = '0;
        #3;
        check("rst_hex_out", hex_out, 32'h00FEDEAD);
        check("rst_ledr", ledr_out, 32'h0);
        check("rst_irq", irq, 32'h0);
        step(2);
        reset = 1'b0;
        step(1);

        // Decode and output registers
        rd_chk("hex_rd", 12'h000, 32'h00FEDEAD);
        check("hex_hit", hit, 32'h1);
        rd_chk("gap_rd", 12'h004, 32'h0);
        check("gap_hit", hit, 32'h0);
        rd_chk("win_end_rd", 12'h200, 32'h0);
        check("win_end_hit", hit, 32'h0);
        wr(12'h000, 32'h12345678);
        check("hex_out", hex_out, 32'h00345678);
        rd_chk("hex_rb", 12'h000, 32'h00345678);
        wr(12'h020, 32'hFFFFFFFF);
        check("ledr_out", ledr_out, 32'h3FF);
        rd_chk("ledr_rb", 12'h020, 32'h3FF);
        wr(12'h080, 32'hF);
        rd_chk("kdata_ro", 12'h080, 32'h0);

        // Switch debounce latency and glitch rejection
        sw = 10'h2A5;
        step(5);
        rd_chk("sdata_early", 12'h090, 32'h0);
        step(1);
        rd_chk("sdata", 12'h090, 32'h2A5);
        rd_chk("sctrl_evt", 12'h094, 32'h001);
        sw = 10'h000;
        step(3);
        sw = 10'h2A5;
        step(10);
        rd_chk("sdata_glitch", 12'h090, 32'h2A5);
        rd_chk("sctrl_glitch", 12'h094, 32'h001);
        wr(12'h094, 32'h100);
        rd_chk("sctrl_ie", 12'h094, 32'h100);
        wr(12'h094, 32'h0);
        rd_chk("sctrl_clr", 12'h094, 32'h0);

        // Key events, overrun, write-1-keeps, irq lag
        key_n = 4'hE;
        step(6);
        rd_chk("kdata1", 12'h080, 32'h1);
        rd_chk("kctrl1", 12'h084, 32'h001);
        key_n = 4'hF;
        step(6);
        rd_chk("kdata0", 12'h080, 32'h0);
        rd_chk("kctrl_ovr", 12'h084, 32'h005);
        wr(12'h084, 32'h105);
        rd_chk("kctrl_keep", 12'h084, 32'h105);
        check("irq_key_lag", irq, 32'h0);
        step(1);
        check("irq_key", irq, 32'h1);
        wr(12'h084, 32'h0);
        rd_chk("kctrl_clr", 12'h084, 32'h000);
        step(1);
        check("irq_key_off", irq, 32'h0);
        key_n = 4'hE;
        step(6);
        rd_chk("kctrl_rdy", 12'h084, 32'h001);
        key_n = 4'hC;
        step(5);
        wr(12'h084, 32'h0);
        rd_chk("kctrl_race", 12'h084, 32'h001);
        rd_chk("kdata3", 12'h080, 32'h3);
        wr(12'h084, 32'h0);

        // Timer: TLIM=2 counts 0,1,0 with a tick every 3 clocks
        wr(12'h108, 32'h100);
        wr(12'h104, 32'd2);
        step(2);
        rd_chk("tcnt_a", 12'h100, 32'd0);
        step(1);
        rd_chk("tcnt_b", 12'h100, 32'd1);
        step(2);
        rd_chk("tcnt_c", 12'h100, 32'd1);
        rd_chk("tctl_pre", 12'h108, 32'h100);
        step(1);
        rd_chk("tcnt_wrap", 12'h100, 32'd0);
        rd_chk("tctl_wrap", 12'h108, 32'h101);
        check("irq_t_lag", irq, 32'h0);
        step(1);
        check("irq_t", irq, 32'h1);
        step(2);
        rd_chk("tcnt_d", 12'h100, 32'd1);
        wr(12'h104, 32'd0);
        step(10);
        rd_chk("tcnt_frozen", 12'h100, 32'd1);
        wr(12'h108, 32'h100);
        rd_chk("tctl_clr", 12'h108, 32'h100);

        // TCNT write on the tick that would wrap
        wr(12'h104, 32'd2);
        wr(12'h100, 32'd1);
        step(2);
        wr(12'h100, 32'd5);
        rd_chk("tcnt_wr_tick", 12'h100, 32'd5);
        rd_chk("tctl_nowrap", 12'h108, 32'h100);
        step(2);
        rd_chk("tcnt_hold", 12'h100, 32'd5);
        step(1);
        rd_chk("tcnt_after", 12'h100, 32'd0);
        rd_chk("tctl_after", 12'h108, 32'h101);
        step(1);
        check("irq_pre_rst", irq, 32'h1);

        // Reset mid-debounce and mid-count
        wr(12'h104, 32'd2);
        sw = 10'h000;
        step(3);
        reset = 1'b1;
        #1;
        check("mid_rst_hex", hex_out, 32'h00FEDEAD);
        check("mid_rst_ledr", ledr_out, 32'h0);
        check("mid_rst_irq", irq, 32'h0);
        rd_chk("mid_rst_tlim", 12'h104, 32'h0);
        rd_chk("mid_rst_tctl", 12'h108, 32'h0);
        rd_chk("mid_rst_sdata", 12'h090, 32'h0);
        key_n = 4'hF;
        step(2);
        reset = 1'b0;
        step(12);
        rd_chk("post_sctrl", 12'h094, 32'h0);
        rd_chk("post_kctrl", 12'h084, 32'h0);
        rd_chk("post_sdata", 12'h090, 32'h0);
        rd_chk("post_tcnt", 12'h100, 32'h0);
        check("post_irq", irq, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
